// File: rtl/mda_char_serializer.sv
// MDA character serializer: turns a captured font row + attribute byte into a
// 1-bit video/intensity pixel stream, with CRTC timing delayed to stay aligned.
module mda_char_serializer #(
    parameter int CHAR_WIDTH    = 9,
    parameter int UNDERLINE_ROW = 12,
    parameter int BLINK_BIT     = 4,
    parameter int CURSOR_BIT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] char_code,
    input  logic [7:0] font_bits,
    input  logic [7:0] attr,
    input  logic [4:0] row_addr,
    input  logic       cursor_here,
    input  logic       blink_enable,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    output logic       video,
    output logic       intensity,
    output logic       hsync,
    output logic       vsync,
    output logic       display_enable
);

    localparam int            CW       = $clog2(CHAR_WIDTH + 1);
    localparam logic [CW-1:0] COL_IDLE = CW'(CHAR_WIDTH);
    localparam logic [CW-1:0] COL_EXT  = CW'(8);
    localparam logic [4:0]    UL_ROW   = 5'(UNDERLINE_ROW);

    logic [CW-1:0] col_p0;
    logic [7:0]    font_p0;
    logic [7:0]    attr_p0;
    logic          ext_p0;
    logic          ul_p0;
    logic          cur_p0;
    logic          blink_ph_p0;
    logic          cur_ph_p0;
    logic          vld_p0;

    logic [4:0]    frame_cnt;
    logic          vs_prev;
    logic          vs_rise;

    logic          f_pix;
    logic          blank;
    logic          rev;
    logic          underline;
    logic          pix;
    logic          pix_int;

    assign vs_rise   = vsync_in & ~vs_prev;
    assign vld_p0    = (col_p0 < COL_IDLE);
    assign blank     = ((attr_p0 & 8'h77) == 8'h00);
    assign rev       = ((attr_p0 & 8'h77) == 8'h70);
    assign underline = ((attr_p0 & 8'h07) == 8'h01) && !rev && ul_p0;

    // Stage p0: cell capture and column sequencing. Blink/cursor phases are
    // latched at load so a same-edge vsync increment cannot affect the new cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_p0      <= COL_IDLE;
            font_p0     <= '0;
            attr_p0     <= '0;
            ext_p0      <= 1'b0;
            ul_p0       <= 1'b0;
            cur_p0      <= 1'b0;
            blink_ph_p0 <= 1'b0;
            cur_ph_p0   <= 1'b0;
        end else if (load) begin
            col_p0      <= '0;
            font_p0     <= font_bits;
            attr_p0     <= attr;
            ext_p0      <= (char_code >= 8'hC0) && (char_code <= 8'hDF);
            ul_p0       <= (row_addr == UL_ROW);
            cur_p0      <= cursor_here;
            blink_ph_p0 <= frame_cnt[BLINK_BIT];
            cur_ph_p0   <= frame_cnt[CURSOR_BIT];
        end else if (col_p0 != COL_IDLE) begin
            col_p0 <= col_p0 + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            vs_prev   <= 1'b0;
        end else begin
            vs_prev <= vsync_in;
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
        end
    end

    // Attribute decode; later rules take priority over earlier ones.
    always_comb begin
        f_pix   = 1'b0;
        pix     = 1'b0;
        pix_int = 1'b0;
        if (col_p0 < COL_EXT) begin
            f_pix = font_p0[~col_p0[2:0]];
        end else begin
            f_pix = ext_p0 & font_p0[0];
        end
        pix = rev ? ~f_pix : f_pix;
        if (blank) begin
            pix = 1'b0;
        end
        if (underline) begin
            pix = 1'b1;
        end
        if (blink_enable && attr_p0[7] && blink_ph_p0) begin
            pix = rev;
        end
        if (cur_p0 && cur_ph_p0) begin
            pix = 1'b1;
        end
        // Without blink, attr[7] brightens the lit background of reverse cells.
        if (!blink_enable && rev && !f_pix) begin
            pix_int = attr_p0[7];
        end else begin
            pix_int = attr_p0[3] & pix;
        end
        if (!vld_p0) begin
            pix     = 1'b0;
            pix_int = 1'b0;
        end
    end

    // Stage p1: registered pixel and timing outputs share the same latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video          <= 1'b0;
            intensity      <= 1'b0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
            display_enable <= 1'b0;
        end else begin
            video          <= pix;
            intensity      <= pix_int;
            hsync          <= hsync_in;
            vsync          <= vsync_in;
            display_enable <= de_in;
        end
    end

endmodule

// File: tb/tb_mda_char_serializer.sv
// Self-checking bench for mda_char_serializer using a pixel scoreboard queue.
module tb_mda_char_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] char_code;
    logic [7:0] font_bits;
    logic [7:0] attr;
    logic [4:0] row_addr;
    logic       cursor_here;
    logic       blink_enable;
    logic       hsync_in;
    logic       vsync_in;
    logic       de_in;
    logic       video;
    logic       intensity;
    logic       hsync;
    logic       vsync;
    logic       display_enable;

    int checks = 0;
    int errors = 0;

    logic [1:0] pq[$];
    logic [2:0] sq[$];

    typedef struct packed {
        logic [7:0] f;
        logic [7:0] a;
        logic [7:0] c;
        logic [4:0] r;
        logic [8:0] v;
        logic [8:0] i;
    } cell_t;

    cell_t tbl[13];

    mda_char_serializer dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .char_code      (char_code),
        .font_bits      (font_bits),
        .attr           (attr),
        .row_addr       (row_addr),
        .cursor_here    (cursor_here),
        .blink_enable   (blink_enable),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .de_in          (de_in),
        .video          (video),
        .intensity      (intensity),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_enable (display_enable)
    );

    always #5 clk = ~clk;

    task automatic drive_load(input logic [7:0] f, input logic [7:0] a, input logic [7:0] c,
                              input logic [4:0] r, input logic cur);
        font_bits   = f;
        attr        = a;
        char_code   = c;
        row_addr    = r;
        cursor_here = cur;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    // Expected columns 0..8 (bit 8 = column 0) followed by one idle pixel.
    task automatic push_cell(input logic [8:0] v, input logic [8:0] i);
        for (int k = 0; k < 9; k++) pq.push_back({v[8-k], i[8-k]});
        pq.push_back(2'b00);
    endtask

    task automatic pulse_vsync(input int n);
        for (int p = 0; p < n; p++) begin
            vsync_in = 1'b1;
            @(negedge clk);
            vsync_in = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [4:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        outs = {video, intensity, hsync, vsync, display_enable};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 00000", outs);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({video, intensity} !== 2'b00) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got v=%b i=%b expected v=0 i=0", k, video, intensity);
            end
        end
    endtask

    task automatic test_attr_cells;
        logic [1:0] exp;
        tbl[0]  = '{8'hA5, 8'h07, 8'h41, 5'd0,  9'b101001010, 9'b000000000};
        tbl[1]  = '{8'h0F, 8'h70, 8'h41, 5'd0,  9'b111100001, 9'b000000000};
        tbl[2]  = '{8'h0F, 8'h00, 8'h41, 5'd0,  9'b000000000, 9'b000000000};
        tbl[3]  = '{8'h01, 8'h07, 8'hC4, 5'd0,  9'b000000011, 9'b000000000};
        tbl[4]  = '{8'h01, 8'h07, 8'h41, 5'd0,  9'b000000010, 9'b000000000};
        tbl[5]  = '{8'h01, 8'h07, 8'hDF, 5'd0,  9'b000000011, 9'b000000000};
        tbl[6]  = '{8'h01, 8'h07, 8'hE0, 5'd0,  9'b000000010, 9'b000000000};
        tbl[7]  = '{8'h00, 8'h01, 8'h41, 5'd12, 9'b111111111, 9'b000000000};
        tbl[8]  = '{8'h00, 8'h01, 8'h41, 5'd11, 9'b000000000, 9'b000000000};
        tbl[9]  = '{8'hA5, 8'h0F, 8'h41, 5'd0,  9'b101001010, 9'b101001010};
        tbl[10] = '{8'h0F, 8'hF0, 8'h41, 5'd0,  9'b111100001, 9'b111100001};
        tbl[11] = '{8'h00, 8'h09, 8'h41, 5'd12, 9'b111111111, 9'b111111111};
        tbl[12] = '{8'h0F, 8'h80, 8'h41, 5'd0,  9'b000000000, 9'b000000000};
        blink_enable = 1'b0;
        for (int t = 0; t < 13; t++) begin
            push_cell(tbl[t].v, tbl[t].i);
            drive_load(tbl[t].f, tbl[t].a, tbl[t].c, tbl[t].r, 1'b0);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                exp = pq.pop_front();
                checks++;
                if ({video, intensity} !== exp) begin
                    errors++;
                    $display("FAIL cell%0d col%0d: got v=%b i=%b expected v=%b i=%b",
                             t, k, video, intensity, exp[1], exp[0]);
                end
            end
        end
    endtask

    task automatic test_blink_cursor;
        // pulses before the load, cursor_here, load on a vsync edge, expected video
        int         npulse[9] = '{0, 16, 16, 8, 0, 16, 0, 7, 0};
        logic       cur[9]    = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
        logic       sim[9]    = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [8:0] ev[9]     = '{9'h1FE, 9'h000, 9'h1FE, 9'h1FF, 9'h1FE,
                                  9'h1FF, 9'h000, 9'h000, 9'h1FE};
        logic [1:0] exp;
        blink_enable = 1'b1;
        for (int s = 0; s < 9; s++) begin
            pulse_vsync(npulse[s]);
            push_cell(ev[s], 9'h000);
            if (sim[s]) vsync_in = 1'b1;
            drive_load(8'hFF, 8'h87, 8'h41, 5'd0, cur[s]);
            vsync_in = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                exp = pq.pop_front();
                checks++;
                if ({video, intensity} !== exp) begin
                    errors++;
                    $display("FAIL blink_step%0d col%0d: got v=%b i=%b expected v=%b i=%b",
                             s, k, video, intensity, exp[1], exp[0]);
                end
            end
        end
        blink_enable = 1'b0;
    endtask

    task automatic test_sync_delay;
        logic [2:0] stim;
        logic [2:0] exp;
        for (int k = 0; k < 24; k++) begin
            stim = 3'($urandom_range(0, 7));
            if (k < 4) stim = (k[0]) ? 3'b101 : 3'b000;
            {hsync_in, vsync_in, de_in} = stim;
            sq.push_back(stim);
            @(negedge clk);
            exp = sq.pop_front();
            checks++;
            if ({hsync, vsync, display_enable} !== exp) begin
                errors++;
                $display("FAIL sync_delay cyc%0d: got %b expected %b", k, {hsync, vsync, display_enable}, exp);
            end
        end
        {hsync_in, vsync_in, de_in} = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp;
        for (int k = 0; k < 5; k++) pq.push_back(2'b10);
        push_cell(9'b100000010, 9'h000);
        drive_load(8'hFF, 8'h07, 8'h41, 5'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            if (k == 4) begin
                font_bits = 8'h81;
                attr      = 8'h07;
                char_code = 8'h41;
                load      = 1'b1;
            end
            @(negedge clk);
            if (k == 4) load = 1'b0;
            exp = pq.pop_front();
            checks++;
            if ({video, intensity} !== exp) begin
                errors++;
                $display("FAIL back_to_back step%0d: got v=%b i=%b expected v=%b i=%b",
                         k, video, intensity, exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_reset_mid_cell;
        logic [1:0] exp;
        logic [4:0] outs;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_vsync(16);
        blink_enable = 1'b1;
        push_cell(9'h000, 9'h000);
        drive_load(8'hFF, 8'h87, 8'h41, 5'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp = pq.pop_front();
            checks++;
            if ({video, intensity} !== exp) begin
                errors++;
                $display("FAIL pre_reset_blink col%0d: got v=%b expected v=%b", k, video, exp[1]);
            end
        end
        blink_enable = 1'b0;
        hsync_in = 1'b1;
        de_in    = 1'b1;
        for (int k = 0; k < 3; k++) pq.push_back(2'b11);
        drive_load(8'hFF, 8'h0F, 8'h41, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = pq.pop_front();
            checks++;
            if ({video, intensity} !== exp) begin
                errors++;
                $display("FAIL mid_cell col%0d: got v=%b i=%b expected v=%b i=%b",
                         k, video, intensity, exp[1], exp[0]);
            end
        end
        #2 reset = 1'b1;
        #1 outs = {video, intensity, hsync, vsync, display_enable};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000", outs);
        end
        @(negedge clk);
        reset    = 1'b0;
        hsync_in = 1'b0;
        de_in    = 1'b0;
        for (int k = 0; k < 10; k++) pq.push_back(2'b00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp = pq.pop_front();
            checks++;
            if ({video, intensity} !== exp) begin
                errors++;
                $display("FAIL no_resume cyc%0d: got v=%b i=%b expected v=%b i=%b",
                         k, video, intensity, exp[1], exp[0]);
            end
        end
        blink_enable = 1'b1;
        push_cell(9'h1FE, 9'h000);
        drive_load(8'hFF, 8'h87, 8'h41, 5'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp = pq.pop_front();
            checks++;
            if ({video, intensity} !== exp) begin
                errors++;
                $display("FAIL frame_cnt_cleared col%0d: got v=%b expected v=%b", k, video, exp[1]);
            end
        end
        blink_enable = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        load         = 1'b0;
        char_code    = 8'h00;
        font_bits    = 8'h00;
        attr         = 8'h00;
        row_addr     = 5'd0;
        cursor_here  = 1'b0;
        blink_enable = 1'b0;
        hsync_in     = 1'b0;
        vsync_in     = 1'b0;
        de_in        = 1'b0;
        test_reset();
        test_attr_cells();
        test_blink_cursor();
        test_sync_delay();
        test_back_to_back();
        test_reset_mid_cell();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
